mips_mem_arbiter: RTL and testbench

Single-port memory arbiter directly downstream of the multi-cycle MIPS core. Merges the core's instruction request/response channels and data memory request/response channels onto one shared memory port with valid/ready handshakes. Exactly one outstanding transaction at a time. Responses are routed back to whichever channel issued the request. Also provides three 32-bit occupancy counters for the performance-counter bank.

---
 rtl/mips_mem_arbiter.sv | 145 ++++++++++++++
 tb/tb_mips_mem_arbiter.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_mem_arbiter.sv
// mips_mem_arbiter: merges the core's fetch and data channels onto one
// single-outstanding memory port. Data has priority over fetch; responses
// are steered back to the issuing channel combinationally. Also exposes
// occupancy counters for the performance-counter bank.
module mips_mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    // instruction channel
    input  logic [ADDR_W-1:0]     PC,
    input  logic                  Inst_Req_Valid,
    output logic                  Inst_Req_Ack,
    output logic [DATA_W-1:0]     Instruction,
    output logic                  Inst_Valid,
    input  logic                  Inst_Ack,
    // data channel
    input  logic [ADDR_W-1:0]     Address,
    input  logic                  MemWrite,
    input  logic                  MemRead,
    input  logic [DATA_W-1:0]     Write_data,
    input  logic [DATA_W/8-1:0]   Write_strb,
    output logic                  Mem_Req_Ack,
    output logic [DATA_W-1:0]     Read_data,
    output logic                  Read_data_Valid,
    input  logic                  Read_data_Ack,
    // shared memory port
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic [ADDR_W-1:0]     mem_req_addr,
    output logic                  mem_req_wen,
    output logic [DATA_W-1:0]     mem_req_wdata,
    output logic [DATA_W/8-1:0]   mem_req_wstrb,
    input  logic                  mem_resp_valid,
    output logic                  mem_resp_ready,
    input  logic [DATA_W-1:0]     mem_resp_data,
    // performance counters
    output logic [31:0]           arb_inst_cnt,
    output logic [31:0]           arb_data_cnt,
    output logic [31:0]           arb_wait_cnt
);

    localparam int STRB_W = DATA_W / 8;

    // one-hot state encoding
    localparam logic [4:0] ST_IDLE   = 5'b00001;
    localparam logic [4:0] ST_I_REQ  = 5'b00010;
    localparam logic [4:0] ST_I_RESP = 5'b00100;
    localparam logic [4:0] ST_D_REQ  = 5'b01000;
    localparam logic [4:0] ST_D_RESP = 5'b10000;

    logic [4:0]        state;
    logic [4:0]        state_next;

    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic [STRB_W-1:0] lat_wstrb;
    logic              lat_wen;

    logic is_idle, is_i_req, is_i_resp, is_d_req, is_d_resp;
    logic data_req;

    assign is_idle   = state[0];
    assign is_i_req  = state[1];
    assign is_i_resp = state[2];
    assign is_d_req  = state[3];
    assign is_d_resp = state[4];
    assign data_req  = MemRead | MemWrite;

    // state register; reset abandons any transaction in flight
    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    // next-state: data beats fetch in IDLE; stores skip the response phase
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (data_req)            state_next = ST_D_REQ;
                else if (Inst_Req_Valid) state_next = ST_I_REQ;
            end
            ST_I_REQ:  if (mem_req_ready) state_next = ST_I_RESP;
            ST_I_RESP: if (mem_resp_valid && Inst_Ack) state_next = ST_IDLE;
            ST_D_REQ:  if (mem_req_ready) state_next = lat_wen ? ST_IDLE : ST_D_RESP;
            ST_D_RESP: if (mem_resp_valid && Read_data_Ack) state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    // outputs: request side from latched fields, response side pass-through;
    // handshake outputs held low while rst is asserted so no ack escapes
    always_comb begin
        mem_req_valid   = (is_i_req | is_d_req) & ~rst;
        Inst_Req_Ack    = is_i_req & mem_req_ready & ~rst;
        Mem_Req_Ack     = is_d_req & mem_req_ready & ~rst;
        Inst_Valid      = is_i_resp & mem_resp_valid & ~rst;
        Read_data_Valid = is_d_resp & mem_resp_valid & ~rst;
        mem_resp_ready  = ((is_i_resp & Inst_Ack) | (is_d_resp & Read_data_Ack)) & ~rst;
        Instruction     = is_i_resp ? mem_resp_data : '0;
        Read_data       = is_d_resp ? mem_resp_data : '0;
        mem_req_addr    = lat_addr;
        mem_req_wen     = lat_wen;
        mem_req_wdata   = lat_wdata;
        mem_req_wstrb   = lat_wen ? lat_wstrb : '0;
    end

    // capture the winning request in IDLE; fields hold until the handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_wstrb <= '0;
            lat_wen   <= 1'b0;
        end else if (is_idle) begin
            if (data_req) begin
                lat_addr  <= Address;
                lat_wdata <= Write_data;
                lat_wstrb <= Write_strb;
                lat_wen   <= MemWrite;   // read+write together is a write
            end else if (Inst_Req_Valid) begin
                lat_addr  <= PC;
                lat_wdata <= '0;
                lat_wstrb <= '0;
                lat_wen   <= 1'b0;
            end
        end
    end

    // occupancy counters, free-running and wrapping
    always_ff @(posedge clk) begin
        if (rst) begin
            arb_inst_cnt <= '0;
            arb_data_cnt <= '0;
            arb_wait_cnt <= '0;
        end else begin
            if (is_i_req && mem_req_ready) arb_inst_cnt <= arb_inst_cnt + 32'd1;
            if (is_d_req && mem_req_ready) arb_data_cnt <= arb_data_cnt + 32'd1;
            if ((is_i_req || is_d_req) && !mem_req_ready) arb_wait_cnt <= arb_wait_cnt + 32'd1;
        end
    end

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// Bench for mips_mem_arbiter: table of transactions driven through a
// scoreboard of expected downstream requests and core responses, plus
// hand-written priority and reset sequences.
module tb_mips_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] PC, Address, Write_data, mem_resp_data;
    logic        Inst_Req_Valid, Inst_Ack, MemWrite, MemRead, Read_data_Ack;
    logic [3:0]  Write_strb;
    logic        mem_req_ready, mem_resp_valid;
    logic        Inst_Req_Ack, Inst_Valid, Mem_Req_Ack, Read_data_Valid;
    logic [31:0] Instruction, Read_data;
    logic        mem_req_valid, mem_req_wen, mem_resp_ready;
    logic [31:0] mem_req_addr, mem_req_wdata;
    logic [3:0]  mem_req_wstrb;
    logic [31:0] arb_inst_cnt, arb_data_cnt, arb_wait_cnt;

    mips_mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .PC(PC), .Inst_Req_Valid(Inst_Req_Valid), .Inst_Req_Ack(Inst_Req_Ack),
        .Instruction(Instruction), .Inst_Valid(Inst_Valid), .Inst_Ack(Inst_Ack),
        .Address(Address), .MemWrite(MemWrite), .MemRead(MemRead),
        .Write_data(Write_data), .Write_strb(Write_strb), .Mem_Req_Ack(Mem_Req_Ack),
        .Read_data(Read_data), .Read_data_Valid(Read_data_Valid), .Read_data_Ack(Read_data_Ack),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_addr(mem_req_addr), .mem_req_wen(mem_req_wen),
        .mem_req_wdata(mem_req_wdata), .mem_req_wstrb(mem_req_wstrb),
        .mem_resp_valid(mem_resp_valid), .mem_resp_ready(mem_resp_ready),
        .mem_resp_data(mem_resp_data),
        .arb_inst_cnt(arb_inst_cnt), .arb_data_cnt(arb_data_cnt), .arb_wait_cnt(arb_wait_cnt)
    );

    always #5 clk = ~clk;

    // kind: 0 fetch, 1 load, 2 store, 3 read+write together
    typedef struct {
        int          kind;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        int          rdly;     // REQ cycles before mem_req_ready
        logic [31:0] rdata;
        int          adly;     // response cycles before the core acks
        logic [31:0] e_inst;
        logic [31:0] e_data;
        logic [31:0] e_wait;
    } vec_t;

    typedef struct {
        logic [31:0] addr;
        logic        wen;
        logic [31:0] wdata;
        logic [3:0]  strb;
    } req_t;

    req_t        req_q[$];
    logic [31:0] resp_q[$];
    int          checks = 0;
    int          failures = 0;
    vec_t        vt[5];

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", n, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string n);
        checks++;
        failures++;
        $display("FAIL %s actual=timeout expected=handshake t=%0t", n, $time);
    endtask

    task automatic chk_zero(input string n);
        chk({n, "_ctl"}, {25'd0, Inst_Req_Ack, Inst_Valid, Mem_Req_Ack, Read_data_Valid,
                          mem_req_valid, mem_req_wen, mem_resp_ready}, 32'd0);
        chk({n, "_addr"},  mem_req_addr, 32'd0);
        chk({n, "_wdata"}, mem_req_wdata, 32'd0);
        chk({n, "_wstrb"}, {28'd0, mem_req_wstrb}, 32'd0);
        chk({n, "_instr"}, Instruction, 32'd0);
        chk({n, "_rdata"}, Read_data, 32'd0);
        chk({n, "_icnt"},  arb_inst_cnt, 32'd0);
        chk({n, "_dcnt"},  arb_data_cnt, 32'd0);
        chk({n, "_wcnt"},  arb_wait_cnt, 32'd0);
    endtask

    // Entered and left at a negedge. Drives one core request, plays the
    // memory side, and checks against the scoreboard queues.
    task automatic txn(input vec_t v);
        req_t er;
        req_t got_r;
        logic [31:0] got_d;
        bit   is_f, is_wr, got;
        int   nv;
        is_f  = (v.kind == 0);
        is_wr = (v.kind >= 2);
        er.addr  = v.addr;
        er.wen   = is_wr;
        er.wdata = is_wr ? v.wdata : 32'd0;
        er.strb  = is_wr ? v.strb : 4'd0;
        req_q.push_back(er);
        if (!is_wr) resp_q.push_back(v.rdata);
        if (is_f) begin
            PC = v.addr; Inst_Req_Valid = 1'b1;
        end else begin
            Address = v.addr; Write_data = v.wdata; Write_strb = v.strb;
            MemRead = (v.kind != 2); MemWrite = is_wr;
        end
        got = 0; nv = 0;
        for (int c = 0; c < 40 && !got; c++) begin
            @(negedge clk);
            if (mem_req_valid) begin
                if (nv == 0) chk("req_latency", c, 0);
                if (req_q.size() > 0) begin
                    chk("req_addr", mem_req_addr, req_q[0].addr);
                    chk("req_wen", {31'd0, mem_req_wen}, {31'd0, req_q[0].wen});
                    if (is_wr) chk("req_wdata", mem_req_wdata, req_q[0].wdata);
                    chk("req_wstrb", {28'd0, mem_req_wstrb}, {28'd0, req_q[0].strb});
                end
                mem_req_ready = (nv == v.rdly);
                #1;
                chk("ack_own", {31'd0, is_f ? Inst_Req_Ack : Mem_Req_Ack}, {31'd0, mem_req_ready});
                chk("ack_other", {31'd0, is_f ? Mem_Req_Ack : Inst_Req_Ack}, 32'd0);
                if (mem_req_ready) begin
                    got = 1;
                    got_r = req_q.pop_front();
                    chk("sb_req_addr", mem_req_addr, got_r.addr);
                end
                nv++;
            end
        end
        if (!got) begin
            fail_now("req_timeout");
            mem_req_ready = 1'b0;
            return;
        end
        @(negedge clk);
        #1;
        chk("ack_single_pulse", {30'd0, Inst_Req_Ack, Mem_Req_Ack}, 32'd0);
        mem_req_ready = 1'b0;
        if (is_f) Inst_Req_Valid = 1'b0;
        else begin MemRead = 1'b0; MemWrite = 1'b0; end
        if (is_wr) begin
            // back in IDLE: a stray response must not be forwarded
            mem_resp_valid = 1'b1; mem_resp_data = 32'hBAD0BAD0;
            Read_data_Ack = 1'b1; Inst_Ack = 1'b1;
            #1;
            chk("wr_no_resp", {28'd0, Read_data_Valid, Inst_Valid, mem_resp_ready, mem_req_valid}, 32'd0);
            mem_resp_valid = 1'b0; Read_data_Ack = 1'b0; Inst_Ack = 1'b0;
        end else begin
            got = 0;
            for (int k = 0; k < 40 && !got; k++) begin
                if (k > 0) @(negedge clk);
                mem_resp_valid = 1'b1; mem_resp_data = v.rdata;
                if (is_f) Inst_Ack = (k >= v.adly); else Read_data_Ack = (k >= v.adly);
                #1;
                chk("resp_valid", {31'd0, is_f ? Inst_Valid : Read_data_Valid}, 32'd1);
                chk("resp_other_valid", {31'd0, is_f ? Read_data_Valid : Inst_Valid}, 32'd0);
                chk("resp_ready", {31'd0, mem_resp_ready}, {31'd0, (k >= v.adly)});
                if (k >= v.adly) begin
                    got = 1;
                    got_d = resp_q.pop_front();
                    chk("sb_resp_data", is_f ? Instruction : Read_data, got_d);
                end
            end
            if (!got) fail_now("resp_timeout");
            @(negedge clk);
            mem_resp_valid = 1'b0; Inst_Ack = 1'b0; Read_data_Ack = 1'b0;
            mem_resp_data = 32'd0;
        end
        chk("cnt_inst", arb_inst_cnt, v.e_inst);
        chk("cnt_data", arb_data_cnt, v.e_data);
        chk("cnt_wait", arb_wait_cnt, v.e_wait);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0] = '{0, 32'h0000_0100, 32'h0, 4'h0, 0, 32'h2402_0005, 0, 32'd1, 32'd0, 32'd0};
        vt[1] = '{2, 32'h0000_0200, 32'hDEAD_BEEF, 4'b0011, 3, 32'h0, 0, 32'd1, 32'd1, 32'd3};
        vt[2] = '{1, 32'h0000_0204, 32'h0, 4'h0, 0, 32'h1234_5678, 2, 32'd1, 32'd2, 32'd3};
        vt[3] = '{0, 32'h0000_0104, 32'h0, 4'h0, 1, 32'h8C43_0000, 1, 32'd2, 32'd2, 32'd4};
        vt[4] = '{3, 32'h0000_0208, 32'hCAFE_F00D, 4'hF, 0, 32'h0, 0, 32'd2, 32'd3, 32'd4};

        rst = 1'b1;
        PC = '0; Address = '0; Write_data = '0; Write_strb = '0; mem_resp_data = '0;
        Inst_Req_Valid = 0; Inst_Ack = 0; MemWrite = 0; MemRead = 0; Read_data_Ack = 0;
        mem_req_ready = 0; mem_resp_valid = 0;
        repeat (2) @(negedge clk);
        chk_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 5; i++) txn(vt[i]);

        // data and fetch pending together: load goes first, fetch follows
        PC = 32'h0000_0400; Inst_Req_Valid = 1'b1;
        txn('{1, 32'h0000_0300, 32'h0, 4'h0, 0, 32'hA5A5_0001, 0, 32'd2, 32'd4, 32'd4});
        txn('{0, 32'h0000_0400, 32'h0, 4'h0, 0, 32'h1111_2222, 0, 32'd3, 32'd4, 32'd4});

        // reset while in D_RESP, then a stray response afterwards
        Address = 32'h0000_0500; MemRead = 1'b1;
        @(negedge clk);
        chk("rst_seq_dreq", {31'd0, mem_req_valid}, 32'd1);
        mem_req_ready = 1'b1;
        @(negedge clk);
        MemRead = 1'b0; mem_req_ready = 1'b0;
        mem_resp_valid = 1'b1; mem_resp_data = 32'h5555_AAAA;
        #1;
        chk("rst_seq_dresp", {31'd0, Read_data_Valid}, 32'd1);
        mem_resp_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk_zero("rst_dresp");
        rst = 1'b0;
        mem_resp_valid = 1'b1; Read_data_Ack = 1'b1; Inst_Ack = 1'b1;
        #1;
        chk("stray_resp", {29'd0, Read_data_Valid, Inst_Valid, mem_resp_ready}, 32'd0);
        @(negedge clk);
        chk("stray_resp2", {28'd0, Read_data_Valid, Inst_Valid, mem_resp_ready, mem_req_valid}, 32'd0);
        mem_resp_valid = 1'b0; Read_data_Ack = 1'b0; Inst_Ack = 1'b0;

        // reset while in D_REQ with ready high: no ack, nothing counted
        Address = 32'h0000_0600; MemWrite = 1'b1; Write_data = 32'h0F0F_0F0F; Write_strb = 4'hF;
        @(negedge clk);
        chk("rst_req_valid", {31'd0, mem_req_valid}, 32'd1);
        rst = 1'b1; mem_req_ready = 1'b1;
        #1;
        chk("rst_no_ack", {31'd0, Mem_Req_Ack}, 32'd0);
        @(negedge clk);
        chk_zero("rst_dreq");
        rst = 1'b0; MemWrite = 1'b0; mem_req_ready = 1'b0;
        @(negedge clk);
        chk("post_rst_idle", {31'd0, mem_req_valid}, 32'd0);

        chk("req_q_empty", req_q.size(), 0);
        chk("resp_q_empty", resp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
